// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with load clamp, wrap/saturate modes, cascade TC and registered WRAP pulse.
// Latency: OUT and WRAP update one cycle after the qualifying edge; TC is combinational from current state/inputs.
// No backpressure: every E cycle is a step (or a prescaler tick when MOD_COUNTER_PRESCALE_EN is defined); RST > LOAD > E.
module mod_updown_counter #(
  parameter int           N       = 8,
  parameter logic [N-1:0] RST_VAL = '0
`ifdef MOD_COUNTER_PRESCALE_EN
  ,
  parameter int           P       = 4
`endif
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         E,
  input  logic         D,
  input  logic         LOAD,
  input  logic [N-1:0] DATA_IN,
  input  logic [N-1:0] LIMIT,
  input  logic         SAT,
`ifdef MOD_COUNTER_PRESCALE_EN
  input  logic [P-1:0] PRE_DIV,
`endif
  output logic [N-1:0] OUT,
  output logic         TC,
  output logic         WRAP
);

  // Range-position decode of the current count against the modulus top.
  logic at_top;     // OUT >= LIMIT: next up step leaves the range
  logic above_top;  // OUT >  LIMIT: LIMIT was lowered under the count
  logic at_zero;    // OUT == 0: next down step leaves the range

  // Step qualification: true on cycles where the counter actually moves.
  logic step_en;

  // Next-state of the count and wrap flag for an enabled step.
  logic [N-1:0] step_out;
  logic         step_wrap;

  // Load value after clamping into 0..LIMIT.
  logic [N-1:0] load_val;

`ifdef MOD_COUNTER_PRESCALE_EN
  logic [P-1:0] pre_cnt;
  logic         pre_hit;

  assign pre_hit = (pre_cnt == PRE_DIV);
  assign step_en = E & pre_hit;
`else
  assign step_en = E;
`endif

  assign at_top    = (OUT >= LIMIT);
  assign above_top = (OUT >  LIMIT);
  assign at_zero   = (OUT == '0);

  assign load_val = (DATA_IN <= LIMIT) ? DATA_IN : LIMIT;

  // Terminal count drives the E of a cascaded stage: high only when this cycle's step will wrap.
  assign TC = step_en & ~LOAD & ~RST & ~SAT & ((~D & at_top) | (D & at_zero));

  // Compute the count and wrap flag an enabled step would produce; compare-based so nothing overflows N bits.
  always_comb begin
    step_out  = OUT;
    step_wrap = 1'b0;
    if (!D) begin
      if (at_top) begin
        if (SAT) begin
          // Hold at the top, or pull an out-of-range count back down to it.
          step_out  = LIMIT;
          step_wrap = 1'b0;
        end else begin
          step_out  = '0;
          step_wrap = 1'b1;
        end
      end else begin
        step_out  = OUT + N'(1);
        step_wrap = 1'b0;
      end
    end else begin
      if (above_top) begin
        // Count stranded above a lowered LIMIT re-enters at the top without a wrap.
        step_out  = LIMIT;
        step_wrap = 1'b0;
      end else if (at_zero) begin
        if (SAT) begin
          step_out  = '0;
          step_wrap = 1'b0;
        end else begin
          step_out  = LIMIT;
          step_wrap = 1'b1;
        end
      end else begin
        step_out  = OUT - N'(1);
        step_wrap = 1'b0;
      end
    end
  end

  // Count register and one-cycle wrap pulse with RST > LOAD > E priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT  <= RST_VAL;
      WRAP <= 1'b0;
    end else if (LOAD) begin
      OUT  <= load_val;
      WRAP <= 1'b0;
    end else if (step_en) begin
      OUT  <= step_out;
      WRAP <= step_wrap;
    end else begin
      WRAP <= 1'b0;
    end
  end

`ifdef MOD_COUNTER_PRESCALE_EN
  // Prescaler counts E cycles and restarts on each step; RST and LOAD restart the spacing.
  always_ff @(posedge CLK) begin
    if (RST || LOAD) begin
      pre_cnt <= '0;
    end else if (E) begin
      if (pre_hit) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + P'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter (N = 8, RST_VAL = 0).
// Inputs change 1 ns after each rising edge; outputs are sampled at that point.
// Prescaler scenario is included when MOD_COUNTER_PRESCALE_EN is defined.
module tb_mod_updown_counter;

  logic       CLK;
  logic       RST;
  logic       E;
  logic       D;
  logic       LOAD;
  logic [7:0] DATA_IN;
  logic [7:0] LIMIT;
  logic       SAT;
`ifdef MOD_COUNTER_PRESCALE_EN
  logic [3:0] PRE_DIV;
`endif
  logic [7:0] OUT;
  logic       TC;
  logic       WRAP;

  int checks;
  int failures;

  mod_updown_counter #(
    .N(8),
    .RST_VAL(8'd0)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .E(E),
    .D(D),
    .LOAD(LOAD),
    .DATA_IN(DATA_IN),
    .LIMIT(LIMIT),
    .SAT(SAT),
`ifdef MOD_COUNTER_PRESCALE_EN
    .PRE_DIV(PRE_DIV),
`endif
    .OUT(OUT),
    .TC(TC),
    .WRAP(WRAP)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int up_seq[12]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
  int dn_wrap[5]  = '{2, 1, 0, 5, 4};
  int dn_sat[5]   = '{2, 1, 0, 0, 0};
`ifdef MOD_COUNTER_PRESCALE_EN
  int pre_seq[8]  = '{0, 0, 0, 1, 1, 1, 1, 2};
  int pre_ld[5]   = '{10, 10, 10, 10, 11};
`endif

  initial begin
    checks   = 0;
    failures = 0;
    RST = 1'b1; E = 1'b0; D = 1'b0; LOAD = 1'b0; DATA_IN = 8'd0; LIMIT = 8'd9; SAT = 1'b0;
`ifdef MOD_COUNTER_PRESCALE_EN
    PRE_DIV = 4'd0;
`endif
    tick();
    chk("reset_out", OUT, 0);
    chk("reset_wrap", WRAP, 0);
    chk("reset_tc", TC, 0);

    // Wrap up, LIMIT = 9
    RST = 1'b0; E = 1'b1; D = 1'b0; SAT = 1'b0; LIMIT = 8'd9;
    #1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("up_out[%0d]", i), OUT, up_seq[i]);
      chk($sformatf("up_tc[%0d]", i), TC, (i == 9) ? 1 : 0);
      chk($sformatf("up_wrap[%0d]", i), WRAP, (i == 10) ? 1 : 0);
      tick();
    end
    // Hold with E = 0 (OUT now 2)
    E = 1'b0;
    tick();
    chk("hold_out", OUT, 2);
    chk("hold_wrap", WRAP, 0);
    chk("hold_tc", TC, 0);

    // Wrap down, LIMIT = 5, from 2
    LIMIT = 8'd5; DATA_IN = 8'd2; LOAD = 1'b1; E = 1'b1; D = 1'b1; SAT = 1'b0;
    tick();
    LOAD = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("dn_out[%0d]", i), OUT, dn_wrap[i]);
      chk($sformatf("dn_tc[%0d]", i), TC, (i == 2) ? 1 : 0);
      chk($sformatf("dn_wrap[%0d]", i), WRAP, (i == 3) ? 1 : 0);
      tick();
    end

    // Saturate down from 2
    SAT = 1'b1; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("dsat_out[%0d]", i), OUT, dn_sat[i]);
      chk($sformatf("dsat_tc[%0d]", i), TC, 0);
      chk($sformatf("dsat_wrap[%0d]", i), WRAP, 0);
      tick();
    end

    // Load clamp with E = 1 (load overrides count)
    SAT = 1'b0; D = 1'b0; E = 1'b1; LIMIT = 8'd100; DATA_IN = 8'd200; LOAD = 1'b1;
    tick();
    chk("clamp_out", OUT, 100);
    chk("clamp_wrap", WRAP, 0);
    // RST and LOAD together: TC suppressed, reset wins
    RST = 1'b1; DATA_IN = 8'd50;
    #1;
    chk("rst_tc_mask", TC, 0);
    tick();
    chk("rst_load_out", OUT, 0);
    chk("rst_load_wrap", WRAP, 0);
    RST = 1'b0;
    LOAD = 1'b1; E = 1'b1;
    #1;
    chk("load_tc_mask", TC, 0);

    // Run-time limit drop, up step from 50
    tick();
    chk("ld50_out", OUT, 50);
    LOAD = 1'b0; LIMIT = 8'd20; D = 1'b0;
    #1;
    chk("drop_up_tc", TC, 1);
    tick();
    chk("drop_up_out", OUT, 0);
    chk("drop_up_wrap", WRAP, 1);
    E = 1'b0;
    tick();
    chk("wrap_one_cycle", WRAP, 0);

    // Down step from 50 above lowered limit
    LIMIT = 8'd100; LOAD = 1'b1;
    tick();
    LOAD = 1'b0; LIMIT = 8'd20; D = 1'b1; E = 1'b1;
    #1;
    chk("drop_dn_tc", TC, 0);
    tick();
    chk("drop_dn_out", OUT, 20);
    chk("drop_dn_wrap", WRAP, 0);

    // Up step from 50 in saturate mode clamps to lowered limit
    E = 1'b0; LIMIT = 8'd100; LOAD = 1'b1;
    tick();
    LOAD = 1'b0; LIMIT = 8'd20; D = 1'b0; SAT = 1'b1; E = 1'b1;
    tick();
    chk("drop_sat_out", OUT, 20);
    chk("drop_sat_wrap", WRAP, 0);

    // LIMIT = 0 wrap mode: wrap every cycle
    LIMIT = 8'd0; SAT = 1'b0; RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("lim0_tc", TC, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lim0_out[%0d]", i), OUT, 0);
      chk($sformatf("lim0_wrap[%0d]", i), WRAP, 1);
    end
    SAT = 1'b1;
    #1;
    chk("lim0_sat_tc", TC, 0);
    tick();
    chk("lim0_sat_out", OUT, 0);
    chk("lim0_sat_wrap", WRAP, 0);

    // LIMIT = 255 full binary range
    SAT = 1'b0; LIMIT = 8'd255; DATA_IN = 8'd254; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    tick();
    chk("full_255", OUT, 255);
    chk("full_255_wrap", WRAP, 0);
    chk("full_255_tc", TC, 1);
    tick();
    chk("full_0", OUT, 0);
    chk("full_0_wrap", WRAP, 1);

`ifdef MOD_COUNTER_PRESCALE_EN
    // Prescaler: step every 4th E cycle with PRE_DIV = 3
    E = 1'b0; PRE_DIV = 4'd3; RST = 1'b1;
    tick();
    RST = 1'b0; E = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("pre_out[%0d]", i), OUT, pre_seq[i]);
    end
    tick();
    tick();
    LOAD = 1'b1; DATA_IN = 8'd10;
    tick();
    LOAD = 1'b0;
    chk("pre_load", OUT, 10);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      chk($sformatf("pre_ld_out[%0d]", i), OUT, pre_ld[i]);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
